// File: rtl/cpu_pkg.sv
// Shared CPU types for the decode-stage hazard logic: forwarding select
// encoding and the shadow-pipeline entry that tracks in-flight destinations.
package cpu_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_GPR = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EX  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } shadow_t;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-side handshake bundle: decoded instruction fields and memory wait in,
// forwarding selects and pipeline hold/bubble controls out.
interface decode_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_writes;
    logic              id_is_load;
    logic              mem_wait;
    fwd_sel_t          forward_a;
    fwd_sel_t          forward_b;
    logic              hold_if_id;
    logic              bubble_ex;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_writes, id_is_load, mem_wait,
        input  forward_a, forward_b, hold_if_id, bubble_ex, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_rd, id_writes, id_is_load, mem_wait,
        output forward_a, forward_b, hold_if_id, bubble_ex, stall_count
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one shadow stage against one decode source operand; register 0
// never matches, and the caller folds id_valid into uses.
module hazard_match
    import cpu_pkg::*;
(
    input  shadow_t           stage,
    input  logic [REG_AW-1:0] src,
    input  logic              uses,
    output logic              match,
    output logic              is_load
);

    assign match   = stage.v & stage.wr & (stage.rd == src) & (src != '0) & uses;
    assign is_load = match & stage.ld;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard scheduler: shadows EX/MEM destinations, selects operand
// forwarding, and stalls/bubbles on load-use or freezes on data-memory wait.
module decode_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_hazard_ctrl_if.slave  bus
);

    shadow_t          ex_q;
    shadow_t          mem_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic ex_a_match, ex_a_ld, mem_a_match, mem_a_ld;
    logic ex_b_match, ex_b_ld, mem_b_match, mem_b_ld;
    logic luse;
    logic hold;

    hazard_match u_ex_a (
        .stage(ex_q), .src(bus.id_rs), .uses(bus.id_uses_rs & bus.id_valid),
        .match(ex_a_match), .is_load(ex_a_ld)
    );
    hazard_match u_mem_a (
        .stage(mem_q), .src(bus.id_rs), .uses(bus.id_uses_rs & bus.id_valid),
        .match(mem_a_match), .is_load(mem_a_ld)
    );
    hazard_match u_ex_b (
        .stage(ex_q), .src(bus.id_rt), .uses(bus.id_uses_rt & bus.id_valid),
        .match(ex_b_match), .is_load(ex_b_ld)
    );
    hazard_match u_mem_b (
        .stage(mem_q), .src(bus.id_rt), .uses(bus.id_uses_rt & bus.id_valid),
        .match(mem_b_match), .is_load(mem_b_ld)
    );

    // A matching load never forwards; the consumer waits for the GPR write instead.
    always_comb begin
        bus.forward_a = FWD_GPR;
        bus.forward_b = FWD_GPR;
        if (ex_a_match && !ex_a_ld)        bus.forward_a = FWD_EX;
        else if (mem_a_match && !mem_a_ld) bus.forward_a = FWD_MEM;
        if (ex_b_match && !ex_b_ld)        bus.forward_b = FWD_EX;
        else if (mem_b_match && !mem_b_ld) bus.forward_b = FWD_MEM;
    end

    assign luse            = ex_a_ld | mem_a_ld | ex_b_ld | mem_b_ld;
    assign hold            = bus.mem_wait | luse;
    assign bus.hold_if_id  = hold;
    assign bus.bubble_ex   = luse & ~bus.mem_wait;
    assign bus.stall_count = stall_cnt_q;

    // Memory wait freezes the shadow; a load-use advances MEM but drops EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!bus.mem_wait) begin
                mem_q <= ex_q;
                if (luse) begin
                    ex_q <= '0;
                end else begin
                    ex_q <= '{v:  bus.id_valid,
                              rd: bus.id_rd,
                              wr: bus.id_writes & bus.id_valid,
                              ld: bus.id_is_load};
                end
            end
            if (hold && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
